issue_stage: RTL and testbench

- Sits between the instruction decoder and the execute units.
- Accepts one decoded MicroCode per cycle over a valid/ready handshake and reads rs1/rs2 from the register file, with writeback bypass.
- Blocks RAW and WAW hazards with a per-register busy scoreboard.
- Holds the issued MicroCode plus operands in a single output register for the execute stage; branch-mispredict flush drops the held instruction.

---
 rtl/issue_stage.sv | 128 ++++++++++++
 tb/tb_issue_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// issue_stage: busy-scoreboarded issue with writeback bypass feeding one output register.
// Optional macro ISSUE_STALL_COUNTER_EN adds the stall_cycles counter port.
package issue_pkg;
  typedef struct packed {
    logic [6:0]  op;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] imm;
  } MicroCode;
endpackage

module issue_stage
  import issue_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  MicroCode        dec_mc,
  output logic [4:0]      rf_rs1_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            exe_valid,
  input  logic            exe_ready,
  output MicroCode        exe_mc,
  output logic [XLEN-1:0] exe_rs1_data,
  output logic [XLEN-1:0] exe_rs2_data,
  input  logic            flush
`ifdef ISSUE_STALL_COUNTER_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [NUM_REGS-1:0]   busy_reg, busy_next;
  logic [NUM_REGS-1:0]   eff_busy;
  MicroCode              exe_mc_reg;
  logic [XLEN-1:0]       rs1_data_reg, rs2_data_reg;
  logic [XLEN-1:0]       rs1_data_next, rs2_data_next;
  logic                  hazard, free, issue;

  assign rf_rs1_addr = dec_mc.rs1_addr;
  assign rf_rs2_addr = dec_mc.rs2_addr;

  // A register being written back this cycle is already safe to read.
  assign eff_busy[0] = 1'b0;
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic set_bit, wb_clr, flush_clr;
      assign eff_busy[gi] = busy_reg[gi] && !(wb_en && wb_addr == 5'(gi));
      assign set_bit   = issue && dec_mc.rd_en && dec_mc.rd_addr == 5'(gi);
      assign wb_clr    = wb_en && wb_addr == 5'(gi);
      assign flush_clr = flush && state_reg == FULL && exe_mc_reg.rd_en &&
                         exe_mc_reg.rd_addr == 5'(gi);
      assign busy_next[gi] = set_bit || (busy_reg[gi] && !wb_clr && !flush_clr);
    end
  endgenerate

  assign hazard = eff_busy[dec_mc.rs1_addr] || eff_busy[dec_mc.rs2_addr] ||
                  (dec_mc.rd_en && eff_busy[dec_mc.rd_addr]);
  assign free      = (state_reg == EMPTY) || exe_ready;
  assign dec_ready = !rst && free && !hazard && !flush;
  assign issue     = dec_valid && dec_ready;

  // x0 reads as zero; otherwise the same-cycle writeback overrides the stale file value.
  assign rs1_data_next = (dec_mc.rs1_addr == 5'd0) ? '0 :
                         (wb_en && wb_addr == dec_mc.rs1_addr) ? wb_data : rf_rs1_data;
  assign rs2_data_next = (dec_mc.rs2_addr == 5'd0) ? '0 :
                         (wb_en && wb_addr == dec_mc.rs2_addr) ? wb_data : rf_rs2_data;

  always_comb begin
    state_next = state_reg;
    if (flush)
      state_next = EMPTY;
    else if (issue)
      state_next = FULL;
    else if (state_reg == FULL && exe_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      busy_reg     <= '0;
      exe_mc_reg   <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      if (issue) begin
        exe_mc_reg   <= dec_mc;
        rs1_data_reg <= rs1_data_next;
        rs2_data_reg <= rs2_data_next;
      end
    end
  end

  assign exe_valid    = (state_reg == FULL);
  assign exe_mc       = exe_mc_reg;
  assign exe_rs1_data = rs1_data_reg;
  assign exe_rs2_data = rs2_data_reg;

`ifdef ISSUE_STALL_COUNTER_EN
  logic [31:0] stall_cycles_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles_reg <= '0;
    else if (dec_valid && !dec_ready && !flush)
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
  end
  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus a randomized run
// against a rule-level scoreboard model.
module tb_issue_stage;
  import issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  MicroCode    dec_mc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exe_valid;
  logic        exe_ready;
  MicroCode    exe_mc;
  logic [31:0] exe_rs1_data, exe_rs2_data;
  logic        flush;
`ifdef ISSUE_STALL_COUNTER_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_stage #(.NUM_REGS(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_mc(dec_mc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs1_data(rf_rs1_data),
    .rf_rs2_addr(rf_rs2_addr), .rf_rs2_data(rf_rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_mc(exe_mc),
    .exe_rs1_data(exe_rs1_data), .exe_rs2_data(exe_rs2_data),
    .flush(flush)
`ifdef ISSUE_STALL_COUNTER_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  function automatic MicroCode mk(input logic [6:0] op, input logic rd_en, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    MicroCode m;
    m.op = op; m.rd_en = rd_en; m.rd_addr = rd; m.rs1_addr = rs1; m.rs2_addr = rs2; m.imm = imm;
    return m;
  endfunction

  task automatic idle_inputs();
    dec_valid = 1'b0; dec_mc = '0; rf_rs1_data = '0; rf_rs2_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; exe_ready = 1'b1; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    dec_valid = 1'b1; dec_mc = mk(7'h13, 1'b1, 5'd3, 5'd1, 5'd2, 32'h5);
    rf_rs1_data = 32'hAAAA; rf_rs2_data = 32'hBBBB;
    tick();
    dec_valid = 1'b1; exe_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL reset_exe_valid got=%b exp=0", exe_valid); end
    checks++; if (exe_mc !== MicroCode'('0)) begin failures++; $display("FAIL reset_exe_mc got=%h exp=0", exe_mc); end
    checks++; if (exe_rs1_data !== 32'h0 || exe_rs2_data !== 32'h0) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0/0", exe_rs1_data, exe_rs2_data); end
    checks++; if (dut.busy_reg !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", dut.busy_reg); end
    checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL reset_dec_ready got=%b exp=0", dec_ready); end
    tick();
    rst = 1'b0;
    idle_inputs();
    dec_valid = 1'b1; dec_mc = mk(7'h13, 1'b1, 5'd3, 5'd1, 5'd2, 32'h5);
    #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", dec_ready); end
`ifdef ISSUE_STALL_COUNTER_EN
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
`endif
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    dec_valid = 1'b1; dec_mc = mk(7'h13, 1'b1, 5'd1, 5'd0, 5'd0, 32'd10);
    #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_a got=%b exp=1", dec_ready); end
    tick();
    checks++; if (exe_valid !== 1'b1 || exe_mc.rd_addr !== 5'd1) begin failures++; $display("FAIL b2b_first got=%b/%0d exp=1/1", exe_valid, exe_mc.rd_addr); end
    dec_mc = mk(7'h13, 1'b1, 5'd2, 5'd0, 5'd0, 32'd20);
    #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_b got=%b exp=1", dec_ready); end
    tick();
    checks++; if (exe_valid !== 1'b1 || exe_mc.rd_addr !== 5'd2 || exe_mc.imm !== 32'd20) begin failures++; $display("FAIL b2b_second got=%b/%0d/%0d exp=1/2/20", exe_valid, exe_mc.rd_addr, exe_mc.imm); end
    checks++; if (dut.busy_reg !== 32'h6) begin failures++; $display("FAIL b2b_busy got=%h exp=6", dut.busy_reg); end
    dec_valid = 1'b0;
    tick();
    checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", exe_valid); end
  endtask

  task automatic test_raw_stall();
    apply_reset();
    dec_valid = 1'b1; dec_mc = mk(7'h33, 1'b1, 5'd5, 5'd0, 5'd0, 32'd0);
    tick();
    dec_mc = mk(7'h33, 1'b1, 5'd6, 5'd5, 5'd0, 32'd0);
    rf_rs1_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_%0d got=%b exp=0", i, dec_ready); end
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_ready got=%b exp=1", dec_ready); end
    tick();
    wb_en = 1'b0; dec_valid = 1'b0;
    checks++; if (exe_valid !== 1'b1 || exe_rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_bypass got=%b/%h exp=1/deadbeef", exe_valid, exe_rs1_data); end
    checks++; if (dut.busy_reg !== 32'h40) begin failures++; $display("FAIL raw_busy got=%h exp=40", dut.busy_reg); end
`ifdef ISSUE_STALL_COUNTER_EN
    checks++; if (stall_cycles !== 32'd3) begin failures++; $display("FAIL raw_stall_cycles got=%0d exp=3", stall_cycles); end
`endif
  endtask

  task automatic test_backpressure();
    MicroCode first;
    apply_reset();
    first = mk(7'h33, 1'b1, 5'd3, 5'd1, 5'd2, 32'h77);
    dec_valid = 1'b1; dec_mc = first; rf_rs1_data = 32'hA1A1A1A1; rf_rs2_data = 32'hB2B2B2B2;
    tick();
    exe_ready = 1'b0; dec_mc = mk(7'h13, 1'b1, 5'd4, 5'd0, 5'd0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      #1;
      checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=0", i, dec_ready); end
      tick();
      checks++; if (exe_valid !== 1'b1 || exe_mc !== first || exe_rs1_data !== 32'hA1A1A1A1 || exe_rs2_data !== 32'hB2B2B2B2)
        begin failures++; $display("FAIL bp_hold_%0d got=%b/%h/%h/%h exp=1/%h/a1a1a1a1/b2b2b2b2", i, exe_valid, exe_mc, exe_rs1_data, exe_rs2_data, first); end
    end
    exe_ready = 1'b1; dec_valid = 1'b0;
    tick();
    checks++; if (exe_valid !== 1'b0 || exe_mc !== first) begin failures++; $display("FAIL bp_consume got=%b/%h exp=0/%h", exe_valid, exe_mc, first); end
    tick();
    checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL bp_single got=%b exp=0", exe_valid); end
  endtask

  task automatic test_flush();
    apply_reset();
    dec_valid = 1'b1; dec_mc = mk(7'h13, 1'b1, 5'd7, 5'd0, 5'd0, 32'h9);
    tick();
    exe_ready = 1'b0; flush = 1'b1; dec_mc = mk(7'h13, 1'b1, 5'd8, 5'd0, 5'd0, 32'h3);
    #1;
    checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", dec_ready); end
    tick();
    flush = 1'b0; dec_valid = 1'b0;
    checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", exe_valid); end
    checks++; if (dut.busy_reg !== 32'h0) begin failures++; $display("FAIL flush_busy got=%h exp=0", dut.busy_reg); end
  endtask

  task automatic test_x0();
    apply_reset();
    dec_valid = 1'b1; dec_mc = mk(7'h13, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1);
    tick();
    checks++; if (dut.busy_reg !== 32'h0) begin failures++; $display("FAIL x0_busy got=%h exp=0", dut.busy_reg); end
    dec_mc = mk(7'h13, 1'b1, 5'd9, 5'd0, 5'd0, 32'h2);
    rf_rs1_data = 32'h1234; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h5555;
    #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL x0_no_stall got=%b exp=1", dec_ready); end
    tick();
    idle_inputs();
    checks++; if (exe_valid !== 1'b1 || exe_rs1_data !== 32'h0) begin failures++; $display("FAIL x0_operand got=%b/%h exp=1/0", exe_valid, exe_rs1_data); end
  endtask

  function automatic bit eff(input logic [31:0] b, input logic [4:0] r, input logic we, input logic [4:0] wa);
    return (r != 5'd0) && b[r] && !(we && wa == r);
  endfunction

  task automatic test_random(input int n);
    logic [31:0] m_busy = '0;
    bit          m_valid = 1'b0;
    MicroCode    m_mc = '0;
    logic [31:0] m_r1 = '0, m_r2 = '0;
    logic [31:0] m_stall = '0;
    bit          exp_ready, issue, hz;
    apply_reset();
    for (int c = 0; c < n; c++) begin
      dec_valid = ($urandom_range(3) != 0);
      dec_mc = mk(7'($urandom), 1'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                  5'($urandom_range(7)), $urandom);
      exe_ready = ($urandom_range(2) != 0);
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(7)); wb_data = $urandom;
      flush = ($urandom_range(15) == 0);
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      #1;
      hz = eff(m_busy, dec_mc.rs1_addr, wb_en, wb_addr) || eff(m_busy, dec_mc.rs2_addr, wb_en, wb_addr) ||
           (dec_mc.rd_en && eff(m_busy, dec_mc.rd_addr, wb_en, wb_addr));
      exp_ready = (!m_valid || exe_ready) && !hz && !flush;
      checks++; if (dec_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, dec_ready, exp_ready); end
      issue = dec_valid && exp_ready;
      if (dec_valid && !exp_ready && !flush) m_stall++;
      if (flush && m_valid && m_mc.rd_en && m_mc.rd_addr != 5'd0) m_busy[m_mc.rd_addr] = 1'b0;
      if (wb_en && wb_addr != 5'd0) m_busy[wb_addr] = 1'b0;
      if (issue && dec_mc.rd_en && dec_mc.rd_addr != 5'd0) m_busy[dec_mc.rd_addr] = 1'b1;
      if (issue) begin
        m_mc = dec_mc;
        m_r1 = (dec_mc.rs1_addr == 5'd0) ? 32'h0 : (wb_en && wb_addr == dec_mc.rs1_addr) ? wb_data : rf_rs1_data;
        m_r2 = (dec_mc.rs2_addr == 5'd0) ? 32'h0 : (wb_en && wb_addr == dec_mc.rs2_addr) ? wb_data : rf_rs2_data;
      end
      m_valid = flush ? 1'b0 : issue ? 1'b1 : exe_ready ? 1'b0 : m_valid;
      tick();
      checks++; if (exe_valid !== m_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, exe_valid, m_valid); end
      checks++; if (exe_mc !== m_mc) begin failures++; $display("FAIL rnd_mc c=%0d got=%h exp=%h", c, exe_mc, m_mc); end
      checks++; if (exe_rs1_data !== m_r1 || exe_rs2_data !== m_r2) begin failures++; $display("FAIL rnd_ops c=%0d got=%h/%h exp=%h/%h", c, exe_rs1_data, exe_rs2_data, m_r1, m_r2); end
      checks++; if (dut.busy_reg !== m_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, dut.busy_reg, m_busy); end
`ifdef ISSUE_STALL_COUNTER_EN
      checks++; if (stall_cycles !== m_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cycles, m_stall); end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_raw_stall();
    test_backpressure();
    test_flush();
    test_x0();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
